// File: rtl/message_scan_driver.sv
// Message buffer and 4-digit scan driver for a common-anode display.
// Feeds 5-bit char codes to the 7-segment decoder and scrolls the window.
module message_scan_driver #(
  parameter int SCAN_CNT = 50000,
  parameter int DEAD_CNT = 2500,
  parameter int ROT_CNT  = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [4:0] wr_char,
  input  logic       rot_en,
  output logic [4:0] char,
  output logic [3:0] an,
  output logic       rot_tick
);

  localparam int SW = $clog2(SCAN_CNT);
  localparam int RW = (ROT_CNT > 1) ? $clog2(ROT_CNT) : 1;

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

  logic [4:0]    mem_q [16];
  logic [3:0]    start_q;
  logic [1:0]    digit_q, digit_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q;
  state_t        state_q, state_d;
  logic [3:0]    an_q, an_d;
  logic [4:0]    char_q;
  logic          tick_q;
  logic          scan_last;
  logic          rot_last;
  logic [3:0]    idx;

  always_comb begin
    scan_last = (cnt_q == SW'(SCAN_CNT - 1));
    cnt_d     = scan_last ? '0 : cnt_q + SW'(1);
    digit_d   = scan_last ? digit_q - 2'd1 : digit_q;
    state_d   = (cnt_d < SW'(DEAD_CNT)) ? BLANK : DRIVE;
    an_d      = (state_d == BLANK) ? 4'b1111
              : ~(4'b0001 << digit_d);
    rot_last  = (rcnt_q == RW'(ROT_CNT - 1));
    // an[3] shows entry[start], an[0] shows entry[start+3]
    idx       = start_q + 4'd3 - {2'b00, digit_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 5'h10;
      end
      start_q <= '0;
      digit_q <= 2'd3;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      state_q <= BLANK;
      an_q    <= 4'b1111;
      char_q  <= 5'h10;
      tick_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_addr] <= wr_char;
      end
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      state_q <= state_d;
      an_q    <= an_d;
      if (state_q == BLANK && cnt_q == '0) begin
        char_q <= mem_q[idx];
      end
      tick_q <= 1'b0;
      if (rot_en) begin
        if (rot_last) begin
          rcnt_q  <= '0;
          start_q <= start_q + 4'd1;
          tick_q  <= 1'b1;
        end else begin
          rcnt_q <= rcnt_q + RW'(1);
        end
      end
    end
  end

  assign char     = char_q;
  assign an       = an_q;
  assign rot_tick = tick_q;

endmodule

// File: tb/tb_message_scan_driver.sv
// Directed bench for message_scan_driver.
// Runs with SCAN_CNT=8, DEAD_CNT=2, ROT_CNT=64.
module tb_message_scan_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [4:0] wr_char = '0;
  logic       rot_en = 1'b0;
  logic [4:0] char;
  logic [3:0] an;
  logic       rot_tick;

  int nvec = 0;
  int nerr = 0;
  int s = 0;

  message_scan_driver #(
    .SCAN_CNT(8),
    .DEAD_CNT(2),
    .ROT_CNT (64)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_char (wr_char),
    .rot_en  (rot_en),
    .char    (char),
    .an      (an),
    .rot_tick(rot_tick)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(negedge clk);
    s++;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    s = 0;
  endtask

  function automatic logic [3:0] an_at(int t);
    int dg;
    dg = 3 - ((t / 8) % 4);
    if ((t % 8) < 2) return 4'b1111;
    return 4'(~(32'd1 << dg));
  endfunction

  task automatic test_reset;
    do_reset();
    rot_en = 1'b0;
    wr_en  = 1'b0;
    while (s < 40) begin
      nvec++;
      if (an !== an_at(s)) begin
        nerr++;
        $display("FAIL reset_an s=%0d got %b want %b", s, an, an_at(s));
      end
      nvec++;
      if (char !== 5'h10) begin
        nerr++;
        $display("FAIL reset_char s=%0d got %h want 10", s, char);
      end
      step();
    end
  endtask

  task automatic test_static;
    logic [4:0] ec;
    do_reset();
    rot_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_char = 5'(i + 1);
      step();
    end
    wr_en = 1'b0;
    while (s < 8) step();
    while (s < 40) begin
      ec = 5'(4 - (3 - ((s / 8) % 4)));
      nvec++;
      if (an !== an_at(s)) begin
        nerr++;
        $display("FAIL static_an s=%0d got %b want %b", s, an, an_at(s));
      end
      if ((s % 8) != 0) begin
        nvec++;
        if (char !== ec) begin
          nerr++;
          $display("FAIL static_char s=%0d got %h want %h", s, char, ec);
        end
      end
      step();
    end
  endtask

  task automatic test_rotation;
    int s0, st, dg;
    logic et;
    logic [4:0] ec;
    do_reset();
    rot_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_char = 5'(i);
      step();
    end
    wr_en  = 1'b0;
    rot_en = 1'b1;
    while (s < 1090) begin
      et = (s >= 80) && (((s - 80) % 64) == 0);
      nvec++;
      if (rot_tick !== et) begin
        nerr++;
        $display("FAIL rot_tick s=%0d got %b want %b", s, rot_tick, et);
      end
      if ((s % 8) == 2) begin
        s0 = s - 2;
        st = (s0 >= 80) ? (((s0 - 80) / 64 + 1) % 16) : 0;
        dg = 3 - ((s / 8) % 4);
        ec = 5'((st + 3 - dg) % 16);
        nvec++;
        if (char !== ec) begin
          nerr++;
          $display("FAIL rot_char s=%0d got %h want %h", s, char, ec);
        end
        nvec++;
        if (an !== an_at(s)) begin
          nerr++;
          $display("FAIL rot_an s=%0d got %b want %b", s, an, an_at(s));
        end
      end
      step();
    end
  endtask

  task automatic test_midwrite;
    do_reset();
    rot_en = 1'b0;
    wr_en  = 1'b0;
    while (s < 3) step();
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_char = 5'h11;
    step();
    wr_en = 1'b0;
    while (s < 8) begin
      nvec++;
      if (char !== 5'h10) begin
        nerr++;
        $display("FAIL mid_hold s=%0d got %h want 10", s, char);
      end
      nvec++;
      if (an !== 4'b0111) begin
        nerr++;
        $display("FAIL mid_an s=%0d got %b want 0111", s, an);
      end
      step();
    end
    wr_en   = 1'b1;
    wr_addr = 4'd1;
    wr_char = 5'h05;
    step();
    wr_en = 1'b0;
    nvec++;
    if (char !== 5'h10) begin
      nerr++;
      $display("FAIL latch_edge_old got %h want 10", char);
    end
    while (s < 33) step();
    nvec++;
    if (char !== 5'h11) begin
      nerr++;
      $display("FAIL mid_new got %h want 11", char);
    end
    while (s < 41) step();
    nvec++;
    if (char !== 5'h05) begin
      nerr++;
      $display("FAIL latch_edge_next got %h want 05", char);
    end
  endtask

  task automatic test_pause;
    logic et;
    do_reset();
    wr_en  = 1'b0;
    rot_en = 1'b1;
    while (s < 170) begin
      if (s == 40) rot_en = 1'b0;
      if (s == 140) rot_en = 1'b1;
      et = (s == 164);
      nvec++;
      if (rot_tick !== et) begin
        nerr++;
        $display("FAIL pause_tick s=%0d got %b want %b", s, rot_tick, et);
      end
      step();
    end
  endtask

  task automatic test_reset_mid;
    logic et;
    do_reset();
    rot_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_char = 5'(i + 8);
      step();
    end
    wr_en = 1'b0;
    while (s < 324) step();
    nvec++;
    if (char !== 5'h0D) begin
      nerr++;
      $display("FAIL pre_reset_char got %h want 0d", char);
    end
    nvec++;
    if (an !== 4'b0111) begin
      nerr++;
      $display("FAIL pre_reset_an got %b want 0111", an);
    end
    do_reset();
    while (s < 70) begin
      et = (s == 64);
      nvec++;
      if (an !== an_at(s)) begin
        nerr++;
        $display("FAIL rst_mid_an s=%0d got %b want %b", s, an, an_at(s));
      end
      nvec++;
      if (char !== 5'h10) begin
        nerr++;
        $display("FAIL rst_mid_char s=%0d got %h want 10", s, char);
      end
      nvec++;
      if (rot_tick !== et) begin
        nerr++;
        $display("FAIL rst_mid_tick s=%0d got %b want %b", s, rot_tick, et);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_rotation();
    test_midwrite();
    test_pause();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
